// File: rtl/jogo_sequencia_param.sv
// ============================================================================
// Module   : jogo_sequencia_param
// Purpose  : Parametrised sequence-memory game core (FSM, counters, edge
//            detector, play register, comparator). Optional per-play timeout
//            is enabled by defining JOGO_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jogo_sequencia_param #(
    parameter int N_CHAVES       = 4,
    parameter int DEPTH          = 16,
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic [N_CHAVES-1:0] chaves,
    input  logic                mem_we,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [N_CHAVES-1:0] mem_dado,
    output logic                pronto,
    output logic                acertou,
    output logic                errou,
    output logic                timeout,
    output logic [N_CHAVES-1:0] leds,
    output logic [3:0]          db_estado,
    output logic [ADDR_W-1:0]   db_contagem,
    output logic [ADDR_W-1:0]   db_rodada,
    output logic [N_CHAVES-1:0] db_memoria,
    output logic                db_tem_jogada
);

    localparam logic [3:0] INICIAL     = 4'h0;
    localparam logic [3:0] PREPARA     = 4'h1;
    localparam logic [3:0] ESPERA      = 4'h2;
    localparam logic [3:0] REGISTRA    = 4'h3;
    localparam logic [3:0] COMPARA     = 4'h4;
    localparam logic [3:0] PROX_POS    = 4'h5;
    localparam logic [3:0] PROX_RODADA = 4'h6;
    localparam logic [3:0] FIM_ACERTO  = 4'hA;
    localparam logic [3:0] FIM_TIMEOUT = 4'hD;
    localparam logic [3:0] FIM_ERRO    = 4'hE;

    localparam logic [ADDR_W-1:0] ULTIMA_POS = ADDR_W'(DEPTH - 1);

    logic [3:0]          estado;
    logic [3:0]          prox_estado;
    logic [N_CHAVES-1:0] mem [DEPTH];
    logic [N_CHAVES-1:0] chaves_q;
    logic [N_CHAVES-1:0] jogada_reg;
    logic [ADDR_W-1:0]   pos;
    logic [ADDR_W-1:0]   rodada;
    logic                jogada;
    logic                escrita_ok;
    logic                igual;
    logic                expirou;

    assign jogada     = (chaves != '0) && (chaves_q == '0);
    assign escrita_ok = (estado == INICIAL) || (estado == FIM_ACERTO) ||
                        (estado == FIM_ERRO) || (estado == FIM_TIMEOUT);
    assign igual      = (jogada_reg == mem[pos]);

    // Sequence memory is deliberately outside the reset domain.
    always_ff @(posedge clock) begin
        if (mem_we && escrita_ok) begin
            mem[mem_addr] <= mem_dado;
        end
    end

`ifdef JOGO_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
    logic [TO_W-1:0] cont_to;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cont_to <= '0;
        end else if (estado == ESPERA) begin
            cont_to <= cont_to + TO_W'(1);
        end else begin
            cont_to <= '0;
        end
    end

    assign expirou = (cont_to == TO_W'(TIMEOUT_CICLOS - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CICLOS > 0);
    assign expirou            = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= prox_estado;
        end
    end

    always_comb begin
        prox_estado = estado;
        case (estado)
            INICIAL:     if (iniciar) prox_estado = PREPARA;
            PREPARA:     prox_estado = ESPERA;
            ESPERA: begin
                // A press in the final cycle of the window beats the timeout.
                if (jogada)       prox_estado = REGISTRA;
                else if (expirou) prox_estado = FIM_TIMEOUT;
            end
            REGISTRA:    prox_estado = COMPARA;
            COMPARA: begin
                if (!igual)                prox_estado = FIM_ERRO;
                else if (pos < rodada)     prox_estado = PROX_POS;
                else if (rodada == ULTIMA_POS) prox_estado = FIM_ACERTO;
                else                       prox_estado = PROX_RODADA;
            end
            PROX_POS:    prox_estado = ESPERA;
            PROX_RODADA: prox_estado = ESPERA;
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: if (iniciar) prox_estado = PREPARA;
            default:     prox_estado = INICIAL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chaves_q   <= '0;
            jogada_reg <= '0;
            pos        <= '0;
            rodada     <= '0;
        end else begin
            chaves_q <= chaves;
            case (estado)
                PREPARA: begin
                    jogada_reg <= '0;
                    pos        <= '0;
                    rodada     <= '0;
                end
                REGISTRA:    jogada_reg <= chaves;
                PROX_POS:    pos <= pos + ADDR_W'(1);
                PROX_RODADA: begin
                    rodada <= rodada + ADDR_W'(1);
                    pos    <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pronto  = 1'b0;
        acertou = 1'b0;
        errou   = 1'b0;
        timeout = 1'b0;
        case (estado)
            FIM_ACERTO: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_ERRO: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                errou   = 1'b1;
`ifdef JOGO_TIMEOUT_EN
                timeout = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    assign leds          = jogada_reg;
    assign db_estado     = estado;
    assign db_contagem   = pos;
    assign db_rodada     = rodada;
    assign db_memoria    = mem[pos];
    assign db_tem_jogada = jogada;

endmodule

`default_nettype wire

// File: tb/tb_jogo_sequencia_param.sv
// ============================================================================
// Module   : tb_jogo_sequencia_param
// Purpose  : Scoreboard bench for jogo_sequencia_param (DEPTH=4, 4 keys).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jogo_sequencia_param;

    typedef struct {
        logic [3:0] estado;
        logic [2:0] flags;      // {acertou, errou, timeout}
        int         rodada;
        int         contagem;
        logic [3:0] leds;
        bit         ended;
    } res_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic [3:0] chaves = 4'd0;
    logic       mem_we = 1'b0;
    logic [1:0] mem_addr = 2'd0;
    logic [3:0] mem_dado = 4'd0;
    logic       pronto, acertou, errou, timeout, db_tem_jogada;
    logic [3:0] leds, db_estado, db_memoria;
    logic [1:0] db_contagem, db_rodada;

    int   total = 0;
    int   bad = 0;
    int   seen_pulses = 0;
    logic [3:0] seq_m [4];
    res_t sb [$];

    jogo_sequencia_param #(
        .N_CHAVES(4), .DEPTH(4), .ADDR_W(2), .TIMEOUT_CICLOS(20)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_dado(mem_dado),
        .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
        .leds(leds), .db_estado(db_estado), .db_contagem(db_contagem),
        .db_rodada(db_rodada), .db_memoria(db_memoria),
        .db_tem_jogada(db_tem_jogada)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Reference: walk rounds 0..3, each demanding positions 0..r in order.
    function automatic res_t ref_game(input logic [3:0] pl[$]);
        res_t o;
        int   k = 0;
        o.estado = 4'h0; o.flags = 3'b000; o.rodada = 0; o.contagem = 0;
        o.leds = 4'h0; o.ended = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p <= r; p++) begin
                if (k >= pl.size()) return o;
                if (pl[k] != seq_m[p]) begin
                    o.estado = 4'hE; o.flags = 3'b010; o.rodada = r;
                    o.contagem = p; o.leds = pl[k]; o.ended = 1'b1;
                    return o;
                end
                k++;
            end
        end
        o.estado = 4'hA; o.flags = 3'b100; o.rodada = 3; o.contagem = 3;
        o.leds = seq_m[3]; o.ended = 1'b1;
        return o;
    endfunction

    // Monitor: pops one expectation every time the game reports an end.
    initial begin
        logic pr_d;
        res_t e;
        pr_d = 1'b0;
        forever begin
            @(negedge clock);
            #1;
            if (db_tem_jogada) seen_pulses++;
            if (pronto && !pr_d) begin
                if (sb.size() == 0) begin
                    chk("unexpected_end", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("end_estado", int'(db_estado), int'(e.estado));
                    chk("end_flags", int'({acertou, errou, timeout}), int'(e.flags));
                    chk("end_rodada", int'(db_rodada), e.rodada);
                    chk("end_contagem", int'(db_contagem), e.contagem);
                    chk("end_leds", int'(leds), int'(e.leds));
                end
            end
            pr_d = pronto;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input logic [3:0] v, input int h, input int g);
        chaves = v;
        tick(h);
        chaves = 4'd0;
        tick(g);
    endtask

    // Leaves the caller at the falling edge inside the PREPARA cycle.
    task automatic start();
        iniciar = 1'b1;
        tick(1);
        iniciar = 1'b0;
    endtask

    task automatic mem_write(input logic [1:0] a, input logic [3:0] v, input bit active);
        mem_we = 1'b1; mem_addr = a; mem_dado = v;
        tick(1);
        mem_we = 1'b0;
        if (!active) seq_m[a] = v;
    endtask

    task automatic play_list(input logic [3:0] pl[$], input int h0);
        int p0;
        p0 = seen_pulses;
        foreach (pl[i]) begin
            int h;
            h = ($urandom_range(0, 5) == 0) ? 10 : $urandom_range(2, 4);
            if (i == 0 && h0 != 0) h = h0;
            press(pl[i], h, $urandom_range(2, 4));
        end
        tick(2);
        chk("pulses", seen_pulses - p0, pl.size());
    endtask

    task automatic run_game(input logic [3:0] pl[$], input int d, input int h0);
        res_t e;
        e = ref_game(pl);
        if (e.ended) sb.push_back(e);
        start();
        tick(d);
        play_list(pl, h0);
    endtask

    initial begin
        logic [3:0] pl[$];
        res_t e;
        logic [3:0] v;
        bit done;

        tick(3);
        reset = 1'b0;
        tick(1);
        chk("rst_flags", int'({pronto, acertou, errou, timeout, db_tem_jogada}), 0);
        chk("rst_estado", int'(db_estado), 0);
        chk("rst_counters", int'({db_contagem, db_rodada}), 0);
        chk("rst_leds", int'(leds), 0);

        mem_write(2'd0, 4'b0001, 0);
        mem_write(2'd1, 4'b0010, 0);
        mem_write(2'd2, 4'b0100, 0);
        mem_write(2'd3, 4'b1000, 0);
        chk("mem0_view", int'(db_memoria), 1);

        // Full win, first press held for 10 cycles.
        pl = '{4'd1, 4'd1, 4'd2, 4'd1, 4'd2, 4'd4, 4'd1, 4'd2, 4'd4, 4'd8};
        run_game(pl, 1, 10);

        // Wrong key in round 2 with exact latency of the error flag.
        pl = '{4'd1, 4'd1, 4'd4};
        sb.push_back(ref_game(pl));
        start();
        tick(1);
        press(4'd1, 2, 2);
        press(4'd1, 2, 2);
        chaves = 4'b0100;
        tick(2);
        chk("err_early", int'(errou), 0);
        tick(1);
        chk("err_latency", int'(errou), 1);
        chk("err_contagem", int'(db_contagem), 1);
        chaves = 4'd0;
        tick(2);

        // Multi-key press at position 0.
        pl = '{4'b0011};
        run_game(pl, 1, 0);

        // Write attempt during play must be ignored.
        pl = '{4'd1, 4'd1, 4'd8};
        sb.push_back(ref_game(pl));
        start();
        tick(1);
        mem_write(2'd0, 4'b1000, 1);
        chk("write_lockout", int'(db_memoria), 1);
        play_list(pl, 0);

        // Write together with restart from FIM_ERRO.
        mem_we = 1'b1; mem_addr = 2'd0; mem_dado = 4'b1000; iniciar = 1'b1;
        seq_m[0] = 4'b1000;
        pl = '{4'd8, 4'd8, 4'd2, 4'd8, 4'd2, 4'd4, 4'd8, 4'd2, 4'd4, 4'd8};
        sb.push_back(ref_game(pl));
        tick(1);
        mem_we = 1'b0; iniciar = 1'b0;
        tick(1);
        chk("write_restart", int'(db_memoria), 8);
        play_list(pl, 0);

        // Reset while in COMPARA.
        mem_write(2'd0, 4'b0001, 0);
        start();
        tick(1);
        chaves = 4'd1;
        tick(2);
        reset = 1'b1;
        chaves = 4'd0;
        #1;
        chk("rst_mid_estado", int'(db_estado), 0);
        chk("rst_mid_flags", int'({pronto, acertou, errou, timeout, leds}), 0);
        tick(1);
        reset = 1'b0;
        tick(1);
        pl = '{4'd1, 4'd1, 4'd3};
        run_game(pl, 1, 0);

`ifdef JOGO_TIMEOUT_EN
        e.estado = 4'hD; e.flags = 3'b011; e.rodada = 0; e.contagem = 0;
        e.leds = 4'd0; e.ended = 1'b1;
        sb.push_back(e);
        start();
        tick(25);
        chk("timeout_estado", int'(db_estado), 13);
`else
        pl = '{4'd1, 4'd2};
        sb.push_back(ref_game(pl));
        start();
        tick(40);
        chk("no_timeout_estado", int'(db_estado), 2);
        chk("no_timeout_flag", int'(timeout), 0);
        play_list(pl, 0);
`endif

        // Press in the last cycle of the timeout window proceeds.
        pl = '{4'd1, 4'd1, 4'd2, 4'd1, 4'd4};
        run_game(pl, 20, 0);

        for (int g = 0; g < 15; g++) begin
            if ($urandom_range(0, 2) == 0) begin
                for (int a = 0; a < 4; a++) begin
                    mem_write(2'(a), 4'($urandom_range(1, 15)), 0);
                end
            end
            pl.delete();
            done = 1'b0;
            for (int r = 0; r < 4 && !done; r++) begin
                for (int p = 0; p <= r && !done; p++) begin
                    if ($urandom_range(0, 14) == 0) begin
                        do v = 4'($urandom_range(1, 15)); while (v == seq_m[p]);
                        pl.push_back(v);
                        done = 1'b1;
                    end else begin
                        pl.push_back(seq_m[p]);
                    end
                end
            end
            run_game(pl, $urandom_range(1, 5), 0);
        end

        tick(5);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
